// File: rtl/aes_shift_mix_columns.sv
// Iterative AES ShiftRows + MixColumns stage, one output column per clock.
// Sits between SubBytes and AddRoundKey; in_last selects the final-round
// form (ShiftRows only). Valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_state    128-bit state, byte i = in_state[8i+7:8i] at row i%4, col i/4
//   in_last     final round: bypass MixColumns
//   in_valid    input block valid
//   in_ready    stage accepts a block this cycle (combinational)
//   out_state   result state, same byte mapping as in_state
//   out_valid   out_state valid
//   out_ready   downstream accepts out_state
module aes_shift_mix_columns #(
  parameter int unsigned COLS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_state,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned STATE_W = 32 * COLS;
  localparam int unsigned CNT_W   = $clog2(COLS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic [STATE_W-1:0] cap_state;
  logic               cap_last;
  logic [CNT_W-1:0]   cnt;

  logic [7:0]  s0, s1, s2, s3;
  logic [7:0]  x0, x1, x2, x3;
  logic [31:0] col_out;

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Byte at (row, col) of a state vector.
  function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] st,
                                          input logic [CNT_W-1:0]   col,
                                          input logic [1:0]         row);
    return st[8 * {col, row} +: 8];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept = in_valid & in_ready;
  end

  // ShiftRows gather for column cnt: row r comes from column cnt+r.
  always_comb begin
    s0 = get_byte(cap_state, cnt,                2'd0);
    s1 = get_byte(cap_state, cnt + CNT_W'(1),    2'd1);
    s2 = get_byte(cap_state, cnt + CNT_W'(2),    2'd2);
    s3 = get_byte(cap_state, cnt + CNT_W'(3),    2'd3);
    x0 = xtime(s0);
    x1 = xtime(s1);
    x2 = xtime(s2);
    x3 = xtime(s3);
    col_out = {s3, s2, s1, s0};
    if (!cap_last) begin
      col_out[7:0]   = x0 ^ (x1 ^ s1) ^ s2 ^ s3;
      col_out[15:8]  = s0 ^ x1 ^ (x2 ^ s2) ^ s3;
      col_out[23:16] = s0 ^ s1 ^ x2 ^ (x3 ^ s3);
      col_out[31:24] = (x0 ^ s0) ^ s1 ^ s2 ^ x3;
    end
  end

  // Input capture, column counter and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state <= '0;
      cap_last  <= 1'b0;
      cnt       <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        cap_state <= in_state;
        cap_last  <= in_last;
        cnt       <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == BUSY) begin
        out_state[32 * cnt +: 32] <= col_out;
      end
      out_valid <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_aes_shift_mix_columns.sv
module tb_aes_shift_mix_columns;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_state;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_state;
  logic         out_valid;
  logic         out_ready;

  int checks;
  int errors;
  int cyc;
  logic [127:0] sb[$];

  localparam logic [127:0] APPB_IN   = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] APPB_MIX  = 128'h4c2606287ad3f8489a19cbe0e5816604;
  localparam logic [127:0] APPB_LAST = 128'he598271ef11141b8ae52b4e0305dbfd4;
  localparam logic [127:0] COL_IN    = 128'h455313db455313db455313db455313db;
  localparam logic [127:0] COL_OUT   = 128'hbca14d8ebca14d8ebca14d8ebca14d8e;

  aes_shift_mix_columns #(.COLS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_state  (in_state),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Generic shift-and-add GF(2^8) multiply for the reference model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic l);
    logic [7:0] m [4][4];
    logic [7:0] sh [4][4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        m[rw][c] = d[8*(4*c+rw) +: 8];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        sh[rw][c] = m[rw][(c+rw)%4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        if (l) begin
          r[8*(4*c+rw) +: 8] = sh[rw][c];
        end else begin
          r[8*(4*c+rw) +: 8] = gmul(8'h02, sh[rw][c]) ^ gmul(8'h03, sh[(rw+1)%4][c])
                             ^ sh[(rw+2)%4][c] ^ sh[(rw+3)%4][c];
        end
      end
    end
    return r;
  endfunction

  // Present a block, push its expected result, return the accept cycle.
  task automatic drive_block(input logic [127:0] d, input logic l,
                             input logic [127:0] exp, output int acc);
    int n;
    sb.push_back(exp);
    in_state = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  // Wait for a result, check latency and data, then release it.
  task automatic wait_out(input int acc, input string name);
    int n;
    logic [127:0] exp;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!out_valid || (cyc - acc) != 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (valid=%0b) required 4", name, cyc - acc, out_valid);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 128'hx;
    checks++;
    if (out_state !== exp) begin
      errors++;
      $display("FAIL %s_data: got %h required %h", name, out_state, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%0b required 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_state = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h required 0", out_state); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int acc;
    drive_block(APPB_IN, 1'b0, APPB_MIX, acc);
    wait_out(acc, "fips_mix");
    drive_block(APPB_IN, 1'b1, APPB_LAST, acc);
    wait_out(acc, "fips_last");
  endtask

  task automatic test_columns();
    int acc;
    drive_block(COL_IN, 1'b0, COL_OUT, acc);
    wait_out(acc, "col_db135345");
    drive_block(128'h0, 1'b0, 128'h0, acc);
    wait_out(acc, "col_zero");
    drive_block({128{1'b1}}, 1'b0, {128{1'b1}}, acc);
    wait_out(acc, "col_ones");
  endtask

  task automatic test_backpressure();
    int acc;
    int n;
    logic [127:0] snap;
    logic [127:0] exp;
    drive_block(APPB_IN, 1'b0, APPB_MIX, acc);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    snap = out_state;
    in_state = COL_IN;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_state !== snap || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: valid=%0b ready=%0b state=%h required valid=1 ready=0 state=%h",
                 out_valid, in_ready, out_state, snap);
      end
      @(posedge clk); #1;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 128'hx;
    checks++;
    if (out_state !== exp) begin errors++; $display("FAIL bp_data: got %h required %h", out_state, exp); end
    out_ready = 1'b1;
    sb.push_back(COL_OUT);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_handoff_ready: got %0b required 1", in_ready); end
    @(posedge clk); #1;
    acc = cyc;
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handoff_drop: out_valid=%0b required 0", out_valid); end
    wait_out(acc, "bp_next");
  endtask

  task automatic test_back_to_back();
    fork
      begin : producer
        logic [127:0] d;
        logic l;
        int n;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
          d = {$urandom, $urandom, $urandom, $urandom};
          l = 1'(i & 1);
          in_state = d;
          in_last = l;
          sb.push_back(model(d, l));
          n = 0;
          while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int got;
        int n;
        int prev;
        logic [127:0] exp;
        got = 0;
        n = 0;
        prev = 0;
        out_ready = 1'b1;
        while (got < 8 && n < 300) begin
          @(posedge clk); #1;
          n++;
          if (out_valid) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 128'hx;
            checks++;
            if (out_state !== exp) begin
              errors++;
              $display("FAIL b2b_data%0d: got %h required %h", got, out_state, exp);
            end
            if (got > 0) begin
              checks++;
              if (cyc - prev != 5) begin
                errors++;
                $display("FAIL b2b_interval%0d: got %0d required 5", got, cyc - prev);
              end
            end
            prev = cyc;
            got++;
          end
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d required 8", got); end
        out_ready = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int acc;
    in_state = COL_IN;
    in_last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (out_state !== 128'h0) begin errors++; $display("FAIL midrst_out_state: got %h required 0", out_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b required 1", in_ready); end
    drive_block(APPB_IN, 1'b0, APPB_MIX, acc);
    wait_out(acc, "midrst_fips");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_fips();
    test_columns();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
